// File: rtl/esm_core_multi_issue.sv
// -----------------------------------------------------------------------------
// esm_core_multi_issue
//
// Unified instruction window with dependency analysis and oldest-first
// multi-issue selection. Decoded instructions are buffered in age order in a
// ring of bs slots. Each cycle, every resident entry is checked for
// RAW/WAW/WAR hazards against older resident entries. Up to IW hazard-free
// entries are then offered to the execution lanes, oldest first.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        global enable (no enqueue, no issue, state holds when low)
//   flush        synchronous window clear, overrides everything but rst
//   in_valid     Instr_in is presented by decode
//   in_ready     window can accept an instruction this cycle
//   Instr_in     instruction word (rd[11:7], rs1[19:15], rs2[24:20])
//   ALUSrc       1 = immediate operand, rs2 is not a source
//   RegWrite     instruction writes rd
//   issue_en     lanes accept the offered grants at this edge
//   issue_valid  per-lane grant flag
//   issue_index  per-lane window slot
//   issue_instr  per-lane instruction word
//   occupancy    allocated span tail - head (includes holes)
// -----------------------------------------------------------------------------
module esm_core_multi_issue #(
  parameter int Instr_word_size = 32,
  parameter int regnum          = 32,
  parameter int bs              = 16,
  parameter int IW              = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Instr_word_size-1:0]    Instr_in,
  input  logic                          ALUSrc,
  input  logic                          RegWrite,
  input  logic                          issue_en,
  output logic [IW-1:0]                 issue_valid,
  output logic [IW*$clog2(bs)-1:0]      issue_index,
  output logic [IW*Instr_word_size-1:0] issue_instr,
  output logic [$clog2(bs):0]           occupancy
);

  localparam int RW = $clog2(regnum);
  localparam int AW = $clog2(bs);
  localparam int PW = AW + 1;

  // Window state: pointers carry an extra wrap bit so full and empty differ.
  logic [bs-1:0]              valid_q, valid_d;
  logic [PW-1:0]              head_q, head_d;
  logic [PW-1:0]              tail_q, tail_d;
  logic [Instr_word_size-1:0] instr_q [bs];
  logic [RW-1:0]              rd_q    [bs];
  logic [RW-1:0]              rs1_q   [bs];
  logic [RW-1:0]              rs2_q   [bs];
  logic [bs-1:0]              uses_rs2_q;
  logic [bs-1:0]              writes_q;

  logic [RW-1:0] rd_in;
  logic [RW-1:0] rs1_in;
  logic [RW-1:0] rs2_in;
  logic          writes_in;

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          enq;
  logic          issue_act;
  logic          commit_en;

  logic [AW-1:0] age [bs];
  logic [bs-1:0] ready;

  logic [AW-1:0] grant_slot [IW];
  logic [IW-1:0] grant_found;
  logic [bs-1:0] grant_mask;

  // Hazard between a younger entry (y) and an older entry (o).
  // A "writes" flag is never set for rd == x0, so register 0 cannot produce a
  // RAW, WAW or WAR match through any of the terms below.
  function automatic logic has_hazard(
    input logic [RW-1:0] rd_y,
    input logic [RW-1:0] rs1_y,
    input logic [RW-1:0] rs2_y,
    input logic          use2_y,
    input logic          wr_y,
    input logic [RW-1:0] rd_o,
    input logic [RW-1:0] rs1_o,
    input logic [RW-1:0] rs2_o,
    input logic          use2_o,
    input logic          wr_o
  );
    logic raw;
    logic waw;
    logic war;
    raw = wr_o && ((rd_o == rs1_y) || (use2_y && (rd_o == rs2_y)));
    waw = wr_y && wr_o && (rd_o == rd_y);
    war = wr_y && ((rd_y == rs1_o) || (use2_o && (rd_y == rs2_o)));
    return raw || waw || war;
  endfunction

  assign rd_in     = Instr_in[7 +: RW];
  assign rs1_in    = Instr_in[15 +: RW];
  assign rs2_in    = Instr_in[20 +: RW];
  assign writes_in = RegWrite && (rd_in != {RW{1'b0}});

  assign head_idx  = head_q[AW-1:0];
  assign tail_idx  = tail_q[AW-1:0];
  assign occupancy = tail_q - head_q;

  // in_ready is forced low while reset is held, independent of start.
  assign in_ready  = rst && start && !flush && (occupancy < PW'(bs));
  assign enq       = in_valid && in_ready;
  assign issue_act = start && !flush;
  assign commit_en = issue_act && issue_en;

  // Readiness: an entry is blocked by any older valid entry it conflicts with.
  always_comb begin
    for (int i = 0; i < bs; i++) begin
      age[i] = AW'(i) - head_idx;
    end
    for (int i = 0; i < bs; i++) begin
      ready[i] = valid_q[i];
      for (int j = 0; j < bs; j++) begin
        ready[i] = ready[i] & ~((j != i) && valid_q[j] && (age[j] < age[i]) &&
                   has_hazard(rd_q[i], rs1_q[i], rs2_q[i], uses_rs2_q[i], writes_q[i],
                              rd_q[j], rs1_q[j], rs2_q[j], uses_rs2_q[j], writes_q[j]));
      end
    end
  end

  // Selection: walk ages from head; the k-th ready entry found goes to lane k.
  always_comb begin : sel_p
    int            cnt;
    logic [AW-1:0] slot;
    cnt         = 0;
    slot        = {AW{1'b0}};
    grant_found = {IW{1'b0}};
    grant_mask  = {bs{1'b0}};
    for (int k = 0; k < IW; k++) begin
      grant_slot[k] = {AW{1'b0}};
    end
    for (int a = 0; a < bs; a++) begin
      slot = head_idx + AW'(a);
      for (int k = 0; k < IW; k++) begin
        if (ready[slot] && (cnt == k)) begin
          grant_slot[k]    = slot;
          grant_found[k]   = 1'b1;
          grant_mask[slot] = 1'b1;
        end else begin
          grant_found[k]   = grant_found[k];
        end
      end
      if (ready[slot]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
  end

  // Lane outputs: grants are offered whether or not issue_en is high.
  always_comb begin
    issue_valid = {IW{1'b0}};
    issue_index = {(IW*AW){1'b0}};
    issue_instr = {(IW*Instr_word_size){1'b0}};
    for (int k = 0; k < IW; k++) begin
      issue_valid[k]                                      = grant_found[k] && issue_act;
      issue_index[k*AW +: AW]                             = grant_slot[k];
      issue_instr[k*Instr_word_size +: Instr_word_size]   = instr_q[grant_slot[k]];
    end
  end

  // Next state: commit clears granted entries, then head jumps to the oldest
  // survivor (reclaiming leading holes) or to the old tail if none survive.
  // An entry enqueued this cycle sits at the old tail, so head landing on the
  // old tail still points at the oldest valid entry.
  always_comb begin : next_p
    logic [bs-1:0] valid_c;
    logic [AW-1:0] slot_h;
    logic          found;
    valid_c = valid_q & ~(commit_en ? grant_mask : {bs{1'b0}});
    slot_h  = {AW{1'b0}};
    found   = 1'b0;
    valid_d = valid_c;
    head_d  = tail_q;
    tail_d  = tail_q;
    if (flush) begin
      valid_d = {bs{1'b0}};
      head_d  = tail_q;
      tail_d  = tail_q;
    end else begin
      for (int a = 0; a < bs; a++) begin
        slot_h = head_idx + AW'(a);
        if (!found && (PW'(a) < occupancy) && valid_c[slot_h]) begin
          head_d = head_q + PW'(a);
          found  = 1'b1;
        end else begin
          found  = found;
        end
      end
      if (enq) begin
        valid_d[tail_idx] = 1'b1;
        tail_d            = tail_q + PW'(1);
      end else begin
        tail_d            = tail_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= {bs{1'b0}};
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry payload, written at the tail on an accepted transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) begin
        instr_q[i] <= {Instr_word_size{1'b0}};
        rd_q[i]    <= {RW{1'b0}};
        rs1_q[i]   <= {RW{1'b0}};
        rs2_q[i]   <= {RW{1'b0}};
      end
      uses_rs2_q <= {bs{1'b0}};
      writes_q   <= {bs{1'b0}};
    end else if (enq) begin
      instr_q[tail_idx]    <= Instr_in;
      rd_q[tail_idx]       <= rd_in;
      rs1_q[tail_idx]      <= rs1_in;
      rs2_q[tail_idx]      <= rs2_in;
      uses_rs2_q[tail_idx] <= ~ALUSrc;
      writes_q[tail_idx]   <= writes_in;
    end else begin
      uses_rs2_q <= uses_rs2_q;
      writes_q   <= writes_q;
    end
  end

endmodule

// File: tb/tb_esm_core_multi_issue.sv
// -----------------------------------------------------------------------------
// Testbench for esm_core_multi_issue (bs=16, IW=2, 32-bit words).
// Stimulus pushes each instruction that is expected to commit, with its
// hand-derived slot, into a scoreboard queue; an independent monitor pops one
// entry per committed lane grant and compares slot and instruction word.
// Directed cycle-level checks cover stalls, timing, full/empty and flush/reset.
// -----------------------------------------------------------------------------
module tb_esm_core_multi_issue;

  localparam int IWS = 32;
  localparam int BS  = 16;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [IWS-1:0] Instr_in;
  logic           ALUSrc;
  logic           RegWrite;
  logic           issue_en;
  logic [IW-1:0]  issue_valid;
  logic [IW*4-1:0]   issue_index;
  logic [IW*IWS-1:0] issue_instr;
  logic [4:0]     occupancy;

  esm_core_multi_issue #(.Instr_word_size(IWS), .regnum(32), .bs(BS), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .Instr_in(Instr_in),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .issue_en(issue_en),
    .issue_valid(issue_valid), .issue_index(issue_index),
    .issue_instr(issue_instr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  slot;
    logic [31:0] ins;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   passes   = 0;
  int   slot_ctr = 0;

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int tag);
    return {4'(tag), 3'b000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic en);
    in_valid = 1'b0;
    issue_en = en;
  endtask

  // Present one instruction; push it to the scoreboard when it should commit.
  task automatic enq(input logic [31:0] ins, input logic alu, input logic rw,
                     input logic en, input bit push);
    in_valid = 1'b1;
    Instr_in = ins;
    ALUSrc   = alu;
    RegWrite = rw;
    issue_en = en;
    if (push) sbq.push_back({4'(slot_ctr), ins});
    slot_ctr = (slot_ctr + 1) % BS;
  endtask

  // Older/younger pair, observed with issue_en low, then drained.
  task automatic pair(input string nm,
                      input logic [31:0] p, input logic pa, input logic pw,
                      input logic [31:0] y, input logic ya, input logic yw,
                      input logic stall);
    enq(p, pa, pw, 1'b0, 1'b1); cyc();
    enq(y, ya, yw, 1'b0, 1'b1); cyc();
    idle(1'b0); #1;
    check(nm, issue_valid, stall ? 2'b01 : 2'b11);
    cyc();
    idle(1'b1); cyc();
    idle(1'b1); cyc();
    idle(1'b0); #1;
    check({nm, "_drained"}, occupancy, 5'd0);
    cyc();
  endtask

  // Monitor: one scoreboard entry per committed lane, lanes in age order.
  always @(negedge clk) begin
    if (rst && issue_en) begin
      for (int k = 0; k < IW; k++) begin
        if (issue_valid[k]) begin
          checks++;
          if (sbq.size() == 0) begin
            $display("FAIL unexpected_grant: lane %0d got slot %0d, required no grant",
                     k, issue_index[k*4 +: 4]);
          end else begin
            mon_e = sbq.pop_front();
            if (issue_index[k*4 +: 4] == mon_e.slot && issue_instr[k*IWS +: IWS] == mon_e.ins)
              passes++;
            else
              $display("FAIL grant_lane%0d: got slot %0d instr %h, required slot %0d instr %h",
                       k, issue_index[k*4 +: 4], issue_instr[k*IWS +: IWS], mon_e.slot, mon_e.ins);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w_ins;
    int          sx;
    rst = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    Instr_in = 32'd0; ALUSrc = 1'b0; RegWrite = 1'b0; issue_en = 1'b0;

    // Reset state, with start already high.
    @(posedge clk); #1;
    start = 1'b1;
    #1;
    check("reset_occupancy", occupancy, 5'd0);
    check("reset_issue_valid", issue_valid, 2'b00);
    check("reset_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    cyc();

    // Three independent adds.
    enq(mk(1, 10, 11, 1), 1'b0, 1'b1, 1'b1, 1'b1); #1;
    check("new_entry_not_eligible", issue_valid, 2'b00);
    check("in_ready_after_reset", in_ready, 1'b1);
    cyc();
    enq(mk(2, 11, 12, 2), 1'b0, 1'b1, 1'b1, 1'b1); #1;
    check("t1_first_grant", issue_valid, 2'b01);
    cyc();
    enq(mk(3, 10, 12, 3), 1'b0, 1'b1, 1'b0, 1'b1); #1;
    check("t1_occ_hold", occupancy, 5'd1);
    cyc();
    idle(1'b1); #1;
    check("t1_dual_grant", issue_valid, 2'b11);
    check("t1_dual_idx", issue_index, {4'd2, 4'd1});
    cyc();
    idle(1'b0); #1;
    check("t1_empty_occ", occupancy, 5'd0);
    check("t1_empty_iv", issue_valid, 2'b00);
    cyc();

    // RAW chain: x1 <- x2,x3 ; x4 <- x1,x5 (slots 3 and 4).
    enq(mk(1, 2, 3, 4), 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    enq(mk(4, 1, 5, 5), 1'b0, 1'b1, 1'b0, 1'b1); #1;
    check("raw_first_offer", issue_index[3:0], 4'd3);
    cyc();
    idle(1'b0); #1;
    check("raw_stall", issue_valid, 2'b01);
    cyc();
    idle(1'b1); #1;
    check("raw_commit_first", issue_index[3:0], 4'd3);
    cyc();
    idle(1'b1); #1;
    check("raw_second_next_cycle_iv", issue_valid, 2'b01);
    check("raw_second_next_cycle_idx", issue_index[3:0], 4'd4);
    cyc();
    idle(1'b0); #1;
    check("raw_drained", occupancy, 5'd0);
    cyc();

    // Hazard cases.
    pair("waw_stall", mk(6, 8, 9, 6), 1'b0, 1'b1, mk(6, 10, 11, 7), 1'b0, 1'b1, 1'b1);
    pair("war_stall", mk(5, 7, 9, 8), 1'b0, 1'b1, mk(7, 10, 11, 9), 1'b0, 1'b1, 1'b1);
    pair("x0_no_stall", mk(0, 0, 14, 10), 1'b0, 1'b1, mk(0, 0, 13, 11), 1'b0, 1'b1, 1'b0);
    pair("alusrc_no_stall", mk(15, 1, 2, 12), 1'b0, 1'b1, mk(16, 3, 15, 13), 1'b1, 1'b1, 1'b0);

    // Fill with a chain hanging off x20 (writer lands in slot 13).
    w_ins = mk(20, 1, 2, 14);
    enq(w_ins, 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    for (int i = 1; i < 16; i++) begin
      enq(mk(i, 20, 3, i), 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    end
    in_valid = 1'b1; Instr_in = mk(16, 20, 3, 0); ALUSrc = 1'b0; RegWrite = 1'b0;
    issue_en = 1'b1; #1;
    check("full_occupancy", occupancy, 5'd16);
    check("full_in_ready", in_ready, 1'b0);
    check("full_only_head_ready", issue_valid, 2'b01);
    check("full_head_slot", issue_index[3:0], 4'd13);
    cyc();
    enq(mk(16, 20, 3, 0), 1'b0, 1'b0, 1'b1, 1'b1); #1;
    check("after_full_in_ready", in_ready, 1'b1);
    check("after_full_occupancy", occupancy, 5'd15);
    cyc();
    for (int i = 17; i < 36; i++) begin
      enq(mk(i % 32, 20, 3, i % 16), 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b1); cyc();
    end
    idle(1'b0); #1;
    check("wrap_drained", occupancy, 5'd0);
    cyc();

    // Hold issue_en low with two ready entries.
    sx = slot_ctr;
    enq(mk(21, 22, 23, 15), 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    enq(mk(24, 25, 26, 0), 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    for (int r = 0; r < 5; r++) begin
      idle(1'b0); #1;
      check("hold_iv", issue_valid, 2'b11);
      check("hold_idx", issue_index, {4'((sx + 1) % BS), 4'(sx)});
      cyc();
    end
    idle(1'b1); #1;
    check("hold_release_iv", issue_valid, 2'b11);
    cyc();
    idle(1'b0); #1;
    check("hold_both_committed", occupancy, 5'd0);
    cyc();

    // Flush with 7 resident entries; enqueue attempted in the flush cycle.
    for (int i = 0; i < 7; i++) begin
      enq(mk(i + 1, i + 2, i + 3, i), 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    end
    in_valid = 1'b1; Instr_in = mk(9, 9, 9, 9); issue_en = 1'b1; flush = 1'b1; #1;
    check("flush_cycle_in_ready", in_ready, 1'b0);
    check("flush_cycle_iv", issue_valid, 2'b00);
    check("flush_cycle_occ", occupancy, 5'd7);
    cyc();
    flush = 1'b0; idle(1'b0); #1;
    check("after_flush_occ", occupancy, 5'd0);
    check("after_flush_iv", issue_valid, 2'b00);
    cyc();
    enq(mk(27, 28, 29, 1), 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    idle(1'b1); #1;
    check("post_flush_grant", issue_valid, 2'b01);
    cyc();
    idle(1'b0); cyc();

    // Reset asserted while two grants are offered.
    enq(mk(10, 11, 12, 2), 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    enq(mk(13, 14, 15, 3), 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    idle(1'b1); #1;
    check("pre_rst_iv", issue_valid, 2'b11);
    rst = 1'b0; #1;
    check("mid_rst_occ", occupancy, 5'd0);
    check("mid_rst_iv", issue_valid, 2'b00);
    check("mid_rst_in_ready", in_ready, 1'b0);
    cyc();
    rst = 1'b1; slot_ctr = 0;
    enq(mk(30, 11, 12, 4), 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    idle(1'b1); cyc();
    idle(1'b0); cyc();
    cyc();

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
